// File: rtl/ipml_prefetch_rd_stage_v2_pkg.sv
// Shared constants and helpers for the ipml prefetch read stage.
// Holds legal parameter ranges, the underflow counter width and a clog2 helper.
package ipml_prefetch_defs;

  localparam int RAM_LAT_MIN   = 1;
  localparam int RAM_LAT_MAX   = 3;
  localparam int BUF_DEPTH_MIN = 2;
  localparam int BUF_DEPTH_MAX = 8;
  localparam int DATA_W_MAX    = 1152;
  localparam int UFLOW_W       = 16;

  typedef logic [UFLOW_W-1:0] uflow_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/ipml_prefetch_rd_stage_v2_buf.sv
// Circular register buffer with push/pop/clear, head/tail pointers and a level
// counter. Depth need not be a power of two; pointers wrap explicitly.
module ipml_prefetch_buf
  import ipml_prefetch_defs::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int LVL_W  = clog2(DEPTH + 1)
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [LVL_W-1:0]  level
);

  localparam int PTR_W = clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      head  <= '0;
      tail  <= '0;
      level <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      level <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= ptr_next(tail);
      end
      if (pop) head <= ptr_next(head);
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign head_data = mem[head];

  // Issue credit guarantees room; a push into a full buffer means the credit logic broke.
  a_no_overflow: assert property (@(posedge rd_clk) disable iff (rd_rst)
    !(push && !pop && !clear && (level == LVL_W'(DEPTH))));

endmodule

// File: rtl/ipml_prefetch_rd_stage_v2.sv
// Read-side prefetch stage: hides RAM read latency behind a small buffer and
// presents FWFT valid/ready data. Optional underflow counter: IPML_PREFETCH_UFLOW_CNT_EN.
module ipml_prefetch_rd_stage_v2
  import ipml_prefetch_defs::*;
#(
  parameter int DATA_W    = 32,
  parameter int RAM_LAT   = 1,
  parameter int BUF_DEPTH = 2,
  parameter int LVL_W     = clog2(BUF_DEPTH + 1)
) (
  input  logic               rd_clk,
  input  logic               rd_rst,
  input  logic               flush,
  input  logic               ram_empty,
  output logic               ram_rd_en,
  input  logic [DATA_W-1:0]  ram_rd_data,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [LVL_W-1:0]   buf_level,
  output logic [UFLOW_W-1:0] uflow_cnt
);

  localparam int CRD_W = LVL_W + 1;

  if ((RAM_LAT < RAM_LAT_MIN) || (RAM_LAT > RAM_LAT_MAX) ||
      (BUF_DEPTH < BUF_DEPTH_MIN) || (BUF_DEPTH > BUF_DEPTH_MAX) ||
      (BUF_DEPTH < RAM_LAT + 1) || (DATA_W < 1) || (DATA_W > DATA_W_MAX)) begin : g_cfg_err
    $error("ipml_prefetch_rd_stage_v2: illegal DATA_W/RAM_LAT/BUF_DEPTH combination");
  end

  logic [RAM_LAT-1:0] inflight;
  logic [1:0]         infl_cnt;
  logic [CRD_W-1:0]   committed;
  logic               credit_ok;
  logic               pop;
  logic               push;

  // out_vld/out_rdy: a word transfers on every cycle where both are high;
  // out_data is held stable while out_vld is high and out_rdy is low.
  assign pop  = out_vld & out_rdy & ~flush;
  assign push = inflight[RAM_LAT-1] & ~flush;

  always_comb begin
    infl_cnt = '0;
    for (int i = 0; i < RAM_LAT; i++) infl_cnt = infl_cnt + {1'b0, inflight[i]};
  end

  // Buffered plus in-flight words, less this cycle's pop, must leave a free slot.
  assign committed = {1'b0, buf_level} + CRD_W'(infl_cnt);
  assign credit_ok = committed < (CRD_W'(BUF_DEPTH) + CRD_W'(pop));
  assign ram_rd_en = ~rd_rst & ~flush & ~ram_empty & credit_ok;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst)     inflight <= '0;
    else if (flush) inflight <= '0;
    else            inflight <= (inflight << 1) | RAM_LAT'(ram_rd_en);
  end

  ipml_prefetch_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH),
    .LVL_W  (LVL_W)
  ) u_buf (
    .rd_clk    (rd_clk),
    .rd_rst    (rd_rst),
    .clear     (flush),
    .push      (push),
    .push_data (ram_rd_data),
    .pop       (pop),
    .head_data (out_data),
    .level     (buf_level)
  );

  assign out_vld = (buf_level != '0);

`ifdef IPML_PREFETCH_UFLOW_CNT_EN
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst)
      uflow_cnt <= '0;
    else if (out_rdy && !out_vld && !flush && (uflow_cnt != '1))
      uflow_cnt <= uflow_cnt + 1'b1;
  end
`else
  assign uflow_cnt = '0;
`endif

endmodule

// File: tb/tb_ipml_prefetch_rd_stage_v2.sv
// Directed bench for ipml_prefetch_rd_stage_v2: instance A (RAM_LAT=1, BUF_DEPTH=2)
// and instance B (RAM_LAT=2, BUF_DEPTH=3), each fed by a behavioural FIFO core.
module tb_ipml_prefetch_rd_stage_v2;

`ifdef IPML_PREFETCH_UFLOW_CNT_EN
  localparam bit UF_EN = 1'b1;
`else
  localparam bit UF_EN = 1'b0;
`endif

  logic        rd_clk;
  logic        a_rst, a_flush, a_rd_en, a_out_vld, a_out_rdy;
  logic        b_rst, b_flush, b_rd_en, b_out_vld, b_out_rdy;
  logic        a_empty, b_empty;
  logic [31:0] a_rdata, a_out_data, b_rdata, b_p1, b_out_data;
  logic [1:0]  a_level;
  logic [2:0]  b_level;
  logic [15:0] a_uflow, b_uflow;

  logic [31:0] a_mem [256];
  logic [31:0] b_mem [256];
  int a_wr = 0;
  int a_rd = 0;
  int b_wr = 0;
  int b_rd = 0;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses;
  int got;
  int cyc;

  // clock / reset
  initial begin
    rd_clk = 1'b0;
    forever #5 rd_clk = ~rd_clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 5 ms");
    $fatal(1, "watchdog");
  end

  ipml_prefetch_rd_stage_v2 #(.DATA_W(32), .RAM_LAT(1), .BUF_DEPTH(2)) u_a (
    .rd_clk(rd_clk), .rd_rst(a_rst), .flush(a_flush), .ram_empty(a_empty),
    .ram_rd_en(a_rd_en), .ram_rd_data(a_rdata), .out_data(a_out_data),
    .out_vld(a_out_vld), .out_rdy(a_out_rdy), .buf_level(a_level), .uflow_cnt(a_uflow)
  );

  ipml_prefetch_rd_stage_v2 #(.DATA_W(32), .RAM_LAT(2), .BUF_DEPTH(3)) u_b (
    .rd_clk(rd_clk), .rd_rst(b_rst), .flush(b_flush), .ram_empty(b_empty),
    .ram_rd_en(b_rd_en), .ram_rd_data(b_rdata), .out_data(b_out_data),
    .out_vld(b_out_vld), .out_rdy(b_out_rdy), .buf_level(b_level), .uflow_cnt(b_uflow)
  );

  // behavioural FIFO cores with 1- and 2-cycle read latency
  assign a_empty = (a_rd == a_wr);
  assign b_empty = (b_rd == b_wr);

  always @(posedge rd_clk) begin
    if (a_rd_en) begin
      a_rdata <= a_mem[a_rd[7:0]];
      a_rd    <= a_rd + 1;
    end
  end

  always @(posedge rd_clk) begin
    if (b_rd_en) begin
      b_p1 <= b_mem[b_rd[7:0]];
      b_rd <= b_rd + 1;
    end
    b_rdata <= b_p1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_flush = 1'b0; b_flush = 1'b0;
    a_out_rdy = 1'b0; b_out_rdy = 1'b0;
    a_mem[0] = 32'h11; a_mem[1] = 32'h22; a_mem[2] = 32'h33;
    a_wr = 3;
    for (int i = 0; i < 10; i++) b_mem[i] = 32'hB0 + i;
    b_wr = 10;

    // reset state, cores already non-empty
    repeat (2) @(negedge rd_clk);
    #1;
    chk("a_rst_vld",   a_out_vld,  0);
    chk("a_rst_data",  a_out_data, 0);
    chk("a_rst_level", a_level,    0);
    chk("a_rst_uflow", a_uflow,    0);
    chk("a_rst_rd_en", a_rd_en,    0);
    chk("b_rst_rd_en", b_rd_en,    0);
    chk("b_rst_vld",   b_out_vld,  0);

    // A: empty-to-valid latency and back-to-back pops
    @(negedge rd_clk);
    a_rst = 1'b0; a_out_rdy = 1'b1;
    #1;
    chk("a_issue_c",  a_rd_en,   1);
    chk("a_vld_c",    a_out_vld, 0);
    @(negedge rd_clk); #1;
    chk("a_vld_c1",   a_out_vld, 0);
    chk("a_issue_c1", a_rd_en,   1);
    @(negedge rd_clk); #1;
    chk("a_vld_c2",   a_out_vld,  1);
    chk("a_data_0",   a_out_data, 32'h11);
    @(negedge rd_clk); #1;
    chk("a_data_1",   a_out_data, 32'h22);
    chk("a_no_issue_empty", a_rd_en, 0);
    @(negedge rd_clk); #1;
    chk("a_data_2",   a_out_data, 32'h33);
    chk("a_level_1",  a_level,    1);
    @(negedge rd_clk); #1;
    chk("a_vld_done", a_out_vld, 0);
    chk("a_level_0",  a_level,   0);
    chk("a_uflow_2",  a_uflow,   UF_EN ? 32'd2 : 32'd0);
    repeat (5) @(negedge rd_clk);
    #1;
    chk("a_uflow_7",  a_uflow,   UF_EN ? 32'd7 : 32'd0);
    a_out_rdy = 1'b0;

    // B: backpressure, credit limits issue to BUF_DEPTH words
    @(negedge rd_clk);
    b_rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      pulses += int'(b_rd_en);
      if (i >= 4) chk("b_hold_data", b_out_data, 32'hB0);
      @(negedge rd_clk);
    end
    #1;
    chk("b_pulses", pulses,    3);
    chk("b_level3", b_level,   3);
    chk("b_vld",    b_out_vld, 1);
    b_out_rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (k == 0) chk("b_issue_on_rdy", b_rd_en, 1);
      chk("b_stream_vld",  b_out_vld,  1);
      chk("b_stream_data", b_out_data, 32'hB0 + k);
      @(negedge rd_clk);
    end
    #1;
    chk("b_drain_vld",   b_out_vld, 0);
    chk("b_drain_level", b_level,   0);

    // B: flush with level 1 and two reads in flight, concurrent pop and return
    b_out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) b_mem[10 + i] = 32'hC0 + i;
    b_wr = 14;
    repeat (3) @(negedge rd_clk);
    #1;
    chk("b_pre_flush_level", b_level,    1);
    chk("b_pre_flush_data",  b_out_data, 32'hC0);
    b_flush = 1'b1; b_out_rdy = 1'b1;
    #1;
    chk("b_no_issue_flush", b_rd_en, 0);
    @(negedge rd_clk);
    b_flush = 1'b0; b_out_rdy = 1'b0;
    #1;
    chk("b_flush_vld",   b_out_vld, 0);
    chk("b_flush_level", b_level,   0);
    chk("b_issue_after", b_rd_en,   1);
    @(negedge rd_clk); #1;
    chk("b_drop_1", b_out_vld, 0);
    @(negedge rd_clk); #1;
    chk("b_drop_2", b_out_vld, 0);
    @(negedge rd_clk); #1;
    chk("b_resync_vld",  b_out_vld,  1);
    chk("b_resync_data", b_out_data, 32'hC3);
    b_out_rdy = 1'b1;
    @(negedge rd_clk); #1;
    chk("b_resync_empty", b_level, 0);
    b_out_rdy = 1'b0;

    // B: 100 words with random out_rdy, in-order and lossless across pointer wraps
    for (int i = 0; i < 100; i++) b_mem[14 + i] = 32'h1000 + i;
    b_wr = 114;
    got = 0;
    cyc = 0;
    while (got < 100 && cyc < 3000) begin
      @(negedge rd_clk);
      b_out_rdy = 1'($urandom_range(0, 1));
      #1;
      if (b_out_vld && b_out_rdy) begin
        chk("b_rand_data", b_out_data, 32'h1000 + got);
        got++;
      end
      cyc++;
    end
    chk("b_rand_count", got, 100);
    b_out_rdy = 1'b0;

    // A: asynchronous reset mid-burst, then standard latency for the next word
    @(negedge rd_clk);
    for (int i = 0; i < 6; i++) a_mem[3 + i] = 32'hA0 + i;
    a_wr = 9;
    a_out_rdy = 1'b1;
    @(negedge rd_clk);
    @(negedge rd_clk); #1;
    chk("a_burst_0", a_out_data, 32'hA0);
    @(negedge rd_clk); #1;
    chk("a_burst_1", a_out_data, 32'hA1);
    chk("a_burst_issue", a_rd_en, 1);
    #2;
    a_rst = 1'b1;
    #1;
    chk("a_arst_vld",   a_out_vld,  0);
    chk("a_arst_level", a_level,    0);
    chk("a_arst_rd_en", a_rd_en,    0);
    chk("a_arst_data",  a_out_data, 0);
    @(negedge rd_clk);
    @(negedge rd_clk);
    a_rst = 1'b0;
    #1;
    chk("a_rel_issue", a_rd_en,   1);
    chk("a_rel_vld0",  a_out_vld, 0);
    @(negedge rd_clk); #1;
    chk("a_rel_vld1",  a_out_vld, 0);
    @(negedge rd_clk); #1;
    chk("a_rel_data3", a_out_data, 32'hA3);
    @(negedge rd_clk); #1;
    chk("a_rel_data4", a_out_data, 32'hA4);
    @(negedge rd_clk); #1;
    chk("a_rel_data5", a_out_data, 32'hA5);
    @(negedge rd_clk); #1;
    chk("a_rel_done",  a_out_vld,  0);

    // A: underflow counter saturation (stays 0 when the counter is compiled out)
    repeat (UF_EN ? 70000 : 20) @(negedge rd_clk);
    #1;
    chk("a_uflow_sat", a_uflow, UF_EN ? 32'hFFFF : 32'h0);
    a_out_rdy = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
